piso_stream: RTL and testbench

- Parametrised parallel-in/serial-out shifter and successor to the basic latch-driven PISO.
- Accepts parallel words through a valid/ready handshake and serialises them MSB- or LSB-first.
- Supports a bit-rate clock enable, back-to-back streaming with no dead cycle, a programmable inter-word gap and a sent-word counter.
- Sits between a word producer (FIFO/CPU register) and a serial line driver.

---
 rtl/piso_stream.sv | 179 +++++++++++++++++
 tb/tb_piso_stream.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/piso_stream.sv
// -----------------------------------------------------------------------------
// piso_stream
//
// Parallel-in / serial-out shifter with a valid/ready word interface. Words are
// serialised MSB- or LSB-first, one bit per enabled clock edge (i_en acts as the
// bit-rate strobe). With GAP = 0 a new word is taken on the same edge that
// retires the last bit of the previous one, so the serial stream is contiguous.
// With GAP > 0, GAP idle bit-times follow every word before the next is taken.
//
// Parameters
//   WIDTH       bits per word (>= 2)
//   MSB_FIRST   1: i_din[WIDTH-1] leaves first, 0: i_din[0] leaves first
//   GAP         idle bit-times inserted after each word (0..255)
//   IDLE_LEVEL  o_dout level while no data bit is being sent
//   CNT_W       width of the sent-word counter
//
// Ports
//   i_clk          rising-edge clock
//   i_rst          asynchronous, active-high reset
//   i_en           bit-time enable; the shifter and gap timer advance only
//                  on edges where it is high
//   i_din          parallel word
//   i_din_valid    producer has a word
//   o_din_ready    word on i_din is taken on this edge if i_din_valid is high
//   i_ser          fill bit shifted into the vacated end (for chaining)
//   o_dout         serial data
//   o_dout_valid   o_dout carries a data bit
//   o_last         o_dout is the final bit of the current word
//   o_busy         block is not idle
//   o_words_sent   words completely shifted out, wraps modulo 2**CNT_W
// -----------------------------------------------------------------------------
module piso_stream #(
    parameter int unsigned WIDTH      = 8,
    parameter bit          MSB_FIRST  = 1'b1,
    parameter int unsigned GAP        = 0,
    parameter bit          IDLE_LEVEL = 1'b0,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_din_valid,
    output logic             o_din_ready,
    input  logic             i_ser,
    output logic             o_dout,
    output logic             o_dout_valid,
    output logic             o_last,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_words_sent
);

    localparam int unsigned    BCW     = $clog2(WIDTH);
    localparam logic [BCW-1:0] BitLast = BCW'(WIDTH - 1);
    // Only meaningful when GAP > 0; the gap state is unreachable otherwise.
    localparam logic [7:0]     GapLast = 8'((GAP > 0) ? GAP - 1 : 0);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StGap   = 2'd2
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_shift;
    logic [BCW-1:0]     r_bit_cnt;
    logic [7:0]         r_gap_cnt;
    logic [CNT_W-1:0]   r_words_sent;

    state_t             w_state_nxt;
    logic [WIDTH-1:0]   w_shift_nxt;
    logic [BCW-1:0]     w_bit_cnt_nxt;
    logic [7:0]         w_gap_cnt_nxt;
    logic [CNT_W-1:0]   w_words_sent_nxt;

    logic               w_last_bit;
    logic               w_din_ready;
    logic               w_accept;
    logic               w_out_bit;
    logic [WIDTH-1:0]   w_shifted;

    // Handshake and datapath helpers.
    always_comb begin
        w_last_bit  = (r_state == StShift) && (r_bit_cnt == BitLast);
        // Seamless reload: with no gap, the edge retiring the last bit may
        // also take the next word, so ready depends on i_en combinationally.
        w_din_ready = (r_state == StIdle) || ((GAP == 0) && w_last_bit && i_en);
        w_accept    = i_din_valid && w_din_ready;
        if (MSB_FIRST) begin
            w_out_bit = r_shift[WIDTH-1];
            w_shifted = {r_shift[WIDTH-2:0], i_ser};
        end else begin
            w_out_bit = r_shift[0];
            w_shifted = {i_ser, r_shift[WIDTH-1:1]};
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt      = r_state;
        w_shift_nxt      = r_shift;
        w_bit_cnt_nxt    = r_bit_cnt;
        w_gap_cnt_nxt    = r_gap_cnt;
        w_words_sent_nxt = r_words_sent;

        unique case (r_state)
            StIdle: begin
                // Accepting a word does not wait for a bit-time.
                if (w_accept) begin
                    w_state_nxt   = StShift;
                    w_shift_nxt   = i_din;
                    w_bit_cnt_nxt = '0;
                end
            end

            StShift: begin
                if (i_en) begin
                    if (w_last_bit) begin
                        w_words_sent_nxt = r_words_sent + CNT_W'(1);
                        if (w_accept) begin
                            w_shift_nxt   = i_din;
                            w_bit_cnt_nxt = '0;
                        end else if (GAP > 0) begin
                            w_state_nxt   = StGap;
                            w_gap_cnt_nxt = '0;
                        end else begin
                            w_state_nxt   = StIdle;
                        end
                    end else begin
                        w_shift_nxt   = w_shifted;
                        w_bit_cnt_nxt = r_bit_cnt + BCW'(1);
                    end
                end
            end

            StGap: begin
                if (i_en) begin
                    if (r_gap_cnt == GapLast) begin
                        w_state_nxt = StIdle;
                    end else begin
                        w_gap_cnt_nxt = r_gap_cnt + 8'd1;
                    end
                end
            end

            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    // State registers; reset discards any word in flight without counting it.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= StIdle;
            r_shift      <= '0;
            r_bit_cnt    <= '0;
            r_gap_cnt    <= '0;
            r_words_sent <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_shift      <= w_shift_nxt;
            r_bit_cnt    <= w_bit_cnt_nxt;
            r_gap_cnt    <= w_gap_cnt_nxt;
            r_words_sent <= w_words_sent_nxt;
        end
    end

    // Outputs decode from registers only (plus i_en for ready).
    always_comb begin
        o_din_ready  = w_din_ready;
        o_dout_valid = (r_state == StShift);
        o_dout       = (r_state == StShift) ? w_out_bit : IDLE_LEVEL;
        o_last       = w_last_bit;
        o_busy       = (r_state != StIdle);
        o_words_sent = r_words_sent;
    end

endmodule

// File: tb/tb_piso_stream.sv
module tb_piso_stream;

    // Four configurations run in lockstep on shared stimulus.
    function automatic int p_w(input int k);
        return (k == 3) ? 5 : 8;
    endfunction
    function automatic bit p_msb(input int k);
        return (k == 1) ? 1'b0 : 1'b1;
    endfunction
    function automatic int p_gap(input int k);
        case (k)
            2:       return 3;
            3:       return 1;
            default: return 0;
        endcase
    endfunction
    function automatic bit p_idle(input int k);
        return (k >= 2) ? 1'b1 : 1'b0;
    endfunction
    function automatic int p_cnt(input int k);
        case (k)
            1:       return 2;
            3:       return 3;
            default: return 16;
        endcase
    endfunction

    logic        clk;
    logic        rst;
    logic        en;
    logic        din_valid;
    logic        ser;
    logic [7:0]  din;

    logic [3:0]       dout_v, valid_v, last_v, busy_v, ready_v;
    logic [3:0][15:0] ws_v;

    // Snapshots taken at the compare point of the most recent cycle.
    logic [3:0]       s_dout, s_valid, s_last, s_ready;
    logic [3:0][15:0] s_ws;

    int checks;
    int errors;

    // Reference model: per instance, a FIFO of pending bit-time slots.
    // Slot encoding: bit0 = data value, bit1 = data slot, bit2 = last bit.
    int         sym [4][64];
    int         qh  [4];
    int         qn  [4];
    int         ws_m[4];
    logic [3:0] exp_rdy;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int W  = p_w(g);
        localparam int CW = p_cnt(g);
        logic [CW-1:0] ws_w;

        piso_stream #(
            .WIDTH      (W),
            .MSB_FIRST  (p_msb(g)),
            .GAP        (p_gap(g)),
            .IDLE_LEVEL (p_idle(g)),
            .CNT_W      (CW)
        ) u_dut (
            .i_clk        (clk),
            .i_rst        (rst),
            .i_en         (en),
            .i_din        (din[W-1:0]),
            .i_din_valid  (din_valid),
            .o_din_ready  (ready_v[g]),
            .i_ser        (ser),
            .o_dout       (dout_v[g]),
            .o_dout_valid (valid_v[g]),
            .o_last       (last_v[g]),
            .o_busy       (busy_v[g]),
            .o_words_sent (ws_w)
        );
        assign ws_v[g] = 16'(ws_w);
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void chk(input string name, input int k,
                                input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d: got 0x%0h, expected 0x%0h (t=%0t)",
                     name, k, act, exp, $time);
        end
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            qh[k]   = 0;
            qn[k]   = 0;
            ws_m[k] = 0;
        end
    endtask

    task automatic push(input int k, input int v);
        sym[k][(qh[k] + qn[k]) % 64] = v;
        qn[k]++;
    endtask

    // One clock edge as seen by the model.
    task automatic model_edge(input int k);
        int s;
        int v;
        int idx;
        bit acc;
        acc = din_valid && exp_rdy[k];
        if (en && qn[k] > 0) begin
            s = sym[k][qh[k]];
            qh[k] = (qh[k] + 1) % 64;
            qn[k]--;
            if (s[2]) ws_m[k] = (ws_m[k] + 1) % (1 << p_cnt(k));
        end
        if (acc) begin
            for (int i = 0; i < p_w(k); i++) begin
                idx = p_msb(k) ? (p_w(k) - 1 - i) : i;
                v = 2 + int'(din[idx]) + ((i == p_w(k) - 1) ? 4 : 0);
                push(k, v);
            end
            for (int j = 0; j < p_gap(k); j++) push(k, 0);
        end
    endtask

    // Compare at the falling edge, then advance the model over the rising edge.
    task automatic cycle();
        @(negedge clk);
        s_dout  = dout_v;
        s_valid = valid_v;
        s_last  = last_v;
        s_ready = ready_v;
        s_ws    = ws_v;
        for (int k = 0; k < 4; k++) begin
            int f;
            bit ev, ed, el, eb, er;
            f  = (qn[k] > 0) ? sym[k][qh[k]] : 0;
            ev = (qn[k] > 0) && f[1];
            ed = ev ? f[0] : p_idle(k);
            el = ev && f[2];
            eb = (qn[k] > 0);
            er = (qn[k] == 0) || ((p_gap(k) == 0) && (qn[k] == 1) && en);
            exp_rdy[k] = er;
            chk("dout",       k, 32'(dout_v[k]),  32'(ed));
            chk("dout_valid", k, 32'(valid_v[k]), 32'(ev));
            chk("last",       k, 32'(last_v[k]),  32'(el));
            chk("busy",       k, 32'(busy_v[k]),  32'(eb));
            chk("din_ready",  k, 32'(ready_v[k]), 32'(er));
            chk("words_sent", k, 32'(ws_v[k]),    ws_m[k]);
        end
        if (!rst) begin
            for (int k = 0; k < 4; k++) model_edge(k);
        end
        @(posedge clk);
        #1;
        ser = 1'($urandom);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        din_valid = 1'b0;
        en        = 1'b0;
        model_reset();
        cycle();
        rst = 1'b0;
    endtask

    logic [7:0]  seq8, lseq8;
    logic [15:0] seq16, vseq16;
    logic [19:0] d20, v20, r20;
    logic [31:0] seq32, rseq32;
    logic [9:0]  wseq;
    int          vcount;

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        en        = 1'b0;
        din_valid = 1'b0;
        din       = 8'h00;
        ser       = 1'b0;
        exp_rdy   = '0;
        model_reset();

        // Reset state, before any clock edge.
        #1;
        chk("rst_dout",  0, 32'(dout_v),  32'h0000000C);
        chk("rst_valid", 0, 32'(valid_v), 32'h0);
        chk("rst_last",  0, 32'(last_v),  32'h0);
        chk("rst_busy",  0, 32'(busy_v),  32'h0);
        chk("rst_ready", 0, 32'(ready_v), 32'h0000000F);
        chk("rst_words", 0, 32'(ws_v[0]), 32'h0);
        cycle();
        rst = 1'b0;

        // MSB-first 0xAA.
        do_reset();
        en = 1'b1; din = 8'hAA; din_valid = 1'b1;
        cycle();
        din_valid = 1'b0;
        seq8 = '0; lseq8 = '0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            seq8  = {seq8[6:0], s_dout[0]};
            lseq8 = {lseq8[6:0], s_last[0]};
        end
        cycle();
        chk("aa_bits",  0, 32'(seq8),     32'h000000AA);
        chk("aa_last",  0, 32'(lseq8),    32'h00000001);
        chk("aa_idle",  0, 32'(s_dout[0]), 32'h0);
        chk("aa_busy",  0, 32'(s_valid[0]), 32'h0);
        chk("aa_words", 0, 32'(s_ws[0]),  32'h1);

        // LSB-first, two words back to back with no dead cycle.
        do_reset();
        en = 1'b1; din = 8'h01; din_valid = 1'b1;
        cycle();
        din = 8'h80;
        seq16 = '0; vseq16 = '0;
        for (int i = 0; i < 16; i++) begin
            if (i == 8) din_valid = 1'b0;
            cycle();
            seq16  = {seq16[14:0], s_dout[1]};
            vseq16 = {vseq16[14:0], s_valid[1]};
        end
        cycle();
        chk("b2b_bits",  1, 32'(seq16),    32'h00008001);
        chk("b2b_valid", 1, 32'(vseq16),   32'h0000FFFF);
        chk("b2b_words", 1, 32'(s_ws[1]),  32'h2);

        // Enable active one cycle in four.
        do_reset();
        en = 1'b0; din = 8'hF0; din_valid = 1'b1;
        cycle();
        din_valid = 1'b0;
        seq32 = '0; rseq32 = '0; vcount = 0;
        for (int i = 0; i < 32; i++) begin
            en = ((i % 4) == 3);
            cycle();
            seq32  = {seq32[30:0], s_dout[0]};
            rseq32 = {rseq32[30:0], s_ready[0]};
            vcount += int'(s_valid[0]);
        end
        en = 1'b0;
        cycle();
        chk("slow_bits",  0, seq32,             32'hFFFF0000);
        chk("slow_ready", 0, rseq32,            32'h00000001);
        chk("slow_span",  0, 32'(vcount),       32'd32);
        chk("slow_words", 0, 32'(s_ws[0]),      32'h1);

        // Inter-word gap of 3 with idle level 1.
        do_reset();
        en = 1'b1; din = 8'h00; din_valid = 1'b1;
        cycle();
        d20 = '0; v20 = '0; r20 = '0;
        for (int i = 0; i < 20; i++) begin
            if (i == 12) din_valid = 1'b0;
            cycle();
            d20 = {d20[18:0], s_dout[2]};
            v20 = {v20[18:0], s_valid[2]};
            r20 = {r20[18:0], s_ready[2]};
        end
        cycle();
        chk("gap_dout",  2, 32'(d20),     32'h00000F00);
        chk("gap_valid", 2, 32'(v20),     32'h000FF0FF);
        chk("gap_ready", 2, 32'(r20),     32'h00000100);
        chk("gap_words", 2, 32'(s_ws[2]), 32'h2);

        // Asynchronous reset in the middle of the second word.
        do_reset();
        en = 1'b1; din = 8'hAA; din_valid = 1'b1;
        cycle();
        for (int i = 0; i < 11; i++) begin
            if (i == 8) din_valid = 1'b0;
            cycle();
        end
        chk("pre_rst_valid", 0, 32'(valid_v[0]), 32'h1);
        chk("pre_rst_words", 0, 32'(ws_v[0]),    32'h1);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("arst_valid", 0, 32'(valid_v),  32'h0);
        chk("arst_busy",  0, 32'(busy_v),   32'h0);
        chk("arst_last",  0, 32'(last_v),   32'h0);
        chk("arst_ready", 0, 32'(ready_v),  32'h0000000F);
        chk("arst_dout",  0, 32'(dout_v),   32'h0000000C);
        chk("arst_words", 0, 32'(ws_v[0]),  32'h0);
        cycle();
        rst = 1'b0;
        din = 8'h3C; din_valid = 1'b1;
        cycle();
        din_valid = 1'b0;
        seq8 = '0; lseq8 = '0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            seq8  = {seq8[6:0], s_dout[0]};
            lseq8 = {lseq8[6:0], s_last[0]};
        end
        cycle();
        chk("fresh_bits",  0, 32'(seq8),    32'h0000003C);
        chk("fresh_last",  0, 32'(lseq8),   32'h00000001);
        chk("fresh_words", 0, 32'(s_ws[0]), 32'h1);

        // Two-bit word counter wraps.
        do_reset();
        en = 1'b1;
        wseq = '0;
        for (int w = 0; w < 5; w++) begin
            din = 8'($urandom);
            din_valid = 1'b1;
            cycle();
            din_valid = 1'b0;
            repeat (8) cycle();
            cycle();
            wseq = {wseq[7:0], s_ws[1][1:0]};
        end
        chk("wrap_seq", 1, 32'(wseq), 32'h000001B1);

        // Randomised traffic with occasional asynchronous resets.
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            case (n / 1000)
                0:       en = 1'b1;
                1:       en = 1'($urandom);
                2:       en = (($urandom % 4) == 0);
                default: en = (($urandom % 4) != 0);
            endcase
            din_valid = (($urandom % 3) != 0);
            din       = 8'($urandom);
            if (($urandom % 300) == 0) begin
                #2;
                rst = 1'b1;
                model_reset();
                cycle();
                rst = 1'b0;
            end else begin
                cycle();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
